// File: rtl/uart_tx_piso_fifo.sv
// uart_tx_piso_fifo: buffered parallel-in/serial-out UART transmitter.
// Frame = start(0), 8 data bits LSB first, parity bit, stop(1).
// Build option: define TX_FIFO_EN for a FIFO_DEPTH-byte circular buffer;
// otherwise a single holding register buffers one byte.
module uart_tx_piso_fifo #(
  parameter int CLKS_PER_BIT = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] din,
  input  logic       parity,
  output logic       tx,
  output logic       strt_beg,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic       ovf,
  output logic       frame_done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  localparam logic [7:0] BAUD_MAX = 8'(CLKS_PER_BIT - 1);

  // Reject parameter values outside the supported ranges at elaboration.
  if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 255 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_cfg_check
    $error("uart_tx_piso_fifo: illegal CLKS_PER_BIT or FIFO_DEPTH");
  end

  logic [2:0] state_q, state_d;
  logic [7:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       tx_d, strt_d;
  logic       baud_last;
  logic       pop;
  logic       push;
  logic [7:0] head;

  assign baud_last  = (baud_q == BAUD_MAX);
  // A byte leaves the buffer either from IDLE or at the very end of STOP.
  assign pop        = !empty && ((state_q == IDLE) || ((state_q == STOP) && baud_last));
  // A write into a full buffer still lands if a pop frees a slot on the same edge.
  assign push       = wr_en && (!full || pop);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == STOP) && baud_last;

`ifdef TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Buffer storage; contents need no reset because the pointers gate validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Read/write pointers carry an extra wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
`else
  logic [7:0] hold_q;
  logic       hold_valid;

  assign full  = hold_valid;
  assign empty = !hold_valid;
  assign head  = hold_q;

  // Single holding register; it frees on the pop so one byte can wait behind the shifter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q     <= '0;
      hold_valid <= 1'b0;
    end else if (push) begin
      hold_q     <= din;
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  // Next-state logic for the frame sequencer, baud counter, bit counter and shifter.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d = head;
          par_d   = (^head) ^ parity;
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = PAR;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      PAR: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (pop) begin
            shift_d = head;
            par_d   = (^head) ^ parity;
            bit_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Line level and frame-enable derived from the upcoming state so both can be registered.
  always_comb begin
    tx_d   = 1'b1;
    strt_d = 1'b0;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA: begin
        tx_d   = shift_d[0];
        strt_d = 1'b1;
      end
      PAR: begin
        tx_d   = par_d;
        strt_d = 1'b1;
      end
      default: tx_d = 1'b1;
    endcase
  end

  // Sequencer state and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx       <= 1'b1;
      strt_beg <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx       <= tx_d;
      strt_beg <= strt_d;
      ovf      <= wr_en && full && !pop;
    end
  end

endmodule

// File: tb/tb_uart_tx_piso_fifo.sv
// tb_uart_tx_piso_fifo: scoreboard bench for uart_tx_piso_fifo.
// One instance at CLKS_PER_BIT=1 is decoded by a frame monitor; a second at
// CLKS_PER_BIT=4 exercises the baud divider. Honours TX_FIFO_EN for buffer depth.
module tb_uart_tx_piso_fifo;

`ifdef TX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       wr_en, parity;
  logic [7:0] din;
  logic       tx, strt_beg, busy, full, empty, ovf, frame_done;
  logic       wr_en4, parity4;
  logic [7:0] din4;
  logic       tx4, strt4, busy4, full4, empty4, ovf4, fd4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       strt_ok;
    logic       fd_ok;
    int         gap;
  } obs_t;

  exp_t sb_q[$];
  obs_t rx_q[$];

  uart_tx_piso_fifo #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst_n), .wr_en(wr_en), .din(din), .parity(parity),
    .tx(tx), .strt_beg(strt_beg), .busy(busy), .full(full), .empty(empty),
    .ovf(ovf), .frame_done(frame_done)
  );

  uart_tx_piso_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst_n), .wr_en(wr_en4), .din(din4), .parity(parity4),
    .tx(tx4), .strt_beg(strt4), .busy(busy4), .full(full4), .empty(empty4),
    .ovf(ovf4), .frame_done(fd4)
  );

  // Reference parity: count ones independently of the design's XOR tree.
  function automatic logic model_par(input logic [7:0] d, input logic odd);
    int n;
    n = $countones(d);
    return odd ? logic'(n % 2 == 0) : logic'(n % 2 == 1);
  endfunction

  // Frame monitor for the CPB=1 instance: decodes each frame into rx_q.
  logic mon_in = 1'b0;
  int   mon_idx = 0;
  int   mon_idle = 0;
  int   fd_count = 0;
  obs_t cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_in   = 1'b0;
      mon_idle = 0;
    end else if (!mon_in) begin
      if (tx == 1'b0) begin
        mon_in       = 1'b1;
        mon_idx      = 1;
        cur.data     = '0;
        cur.gap      = mon_idle;
        cur.strt_ok  = (strt_beg == 1'b0);
        cur.fd_ok    = (frame_done == 1'b0);
      end else begin
        mon_idle++;
      end
    end else begin
      if (mon_idx <= 8) begin
        cur.data[mon_idx-1] = tx;
        cur.strt_ok = cur.strt_ok && (strt_beg == 1'b1);
        cur.fd_ok   = cur.fd_ok && (frame_done == 1'b0);
      end else if (mon_idx == 9) begin
        cur.par     = tx;
        cur.strt_ok = cur.strt_ok && (strt_beg == 1'b1);
        cur.fd_ok   = cur.fd_ok && (frame_done == 1'b0);
      end else begin
        cur.stop    = tx;
        cur.strt_ok = cur.strt_ok && (strt_beg == 1'b0);
        cur.fd_ok   = cur.fd_ok && (frame_done == 1'b1);
        rx_q.push_back(cur);
        mon_in   = 1'b0;
        mon_idle = 0;
      end
      mon_idx++;
    end
  end

  // Count frame_done pulses on the CPB=1 instance.
  always @(negedge clk) begin
    if (rst_n && frame_done) fd_count++;
  end

  task automatic send_byte(input logic [7:0] b, input logic p);
    sb_q.push_back('{data: b, par: model_par(b, p)});
    din    = b;
    parity = p;
    wr_en  = 1'b1;
    @(negedge clk);
    wr_en  = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    @(negedge clk);
    ok = (rx_q.size() >= n);
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    wr_en  = 1'b0; din  = '0; parity  = 1'b0;
    wr_en4 = 1'b0; din4 = '0; parity4 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx, strt_beg, busy, full, empty, ovf, frame_done} !== 7'b1000100)
      $display("[TB] FAIL reset_dut1: got %b expected %b",
               {tx, strt_beg, busy, full, empty, ovf, frame_done}, 7'b1000100);
    checks++;
    if ({tx4, strt4, busy4, full4, empty4, ovf4, fd4} !== 7'b1000100)
      $display("[TB] FAIL reset_dut4: got %b expected %b",
               {tx4, strt4, busy4, full4, empty4, ovf4, fd4}, 7'b1000100);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx, busy, empty} !== 3'b101)
      $display("[TB] FAIL reset_release: got %b expected %b", {tx, busy, empty}, 3'b101);
    errors += ({tx, strt_beg, busy, full, empty, ovf, frame_done} !== 7'b1000100) ? 1 : 0;
    errors += ({tx4, strt4, busy4, full4, empty4, ovf4, fd4} !== 7'b1000100) ? 1 : 0;
    errors += ({tx, busy, empty} !== 3'b101) ? 1 : 0;
  endtask

  task automatic test_even_parity;
    int   fd_before;
    bit   ok;
    exp_t e;
    obs_t o;
    fd_before = fd_count;
    send_byte(8'hA5, 1'b0);
    checks++;
    if ({empty, tx, busy} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL latency_after_write: got %b expected %b", {empty, tx, busy}, 3'b010);
    end
    @(negedge clk);
    checks++;
    if ({tx, busy, empty} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL latency_start: got %b expected %b", {tx, busy, empty}, 3'b011);
    end
    wait_frames(1, 30, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL even_timeout: got %0d frames expected 1", rx_q.size());
    end else begin
      e = sb_q.pop_front();
      o = rx_q.pop_front();
      checks++;
      if (o.data !== e.data) begin
        errors++;
        $display("[TB] FAIL even_data: got %h expected %h", o.data, e.data);
      end
      checks++;
      if (o.par !== e.par) begin
        errors++;
        $display("[TB] FAIL even_par: got %b expected %b", o.par, e.par);
      end
      checks++;
      if ({o.stop, o.strt_ok, o.fd_ok} !== 3'b111) begin
        errors++;
        $display("[TB] FAIL even_framing: got %b expected 111", {o.stop, o.strt_ok, o.fd_ok});
      end
    end
    checks++;
    if (fd_count - fd_before !== 1) begin
      errors++;
      $display("[TB] FAIL even_frame_done_count: got %0d expected 1", fd_count - fd_before);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL even_busy_after: got %b expected 0", busy);
    end
  endtask

  task automatic test_odd_parity;
    bit   ok;
    exp_t e;
    obs_t o;
    logic [7:0] bytes [2];
    bytes[0] = 8'h07;
    bytes[1] = 8'h03;
    for (int i = 0; i < 2; i++) begin
      send_byte(bytes[i], 1'b1);
      @(negedge clk);
      parity = 1'b0;
      din    = 8'hFF;
      wait_frames(1, 30, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("[TB] FAIL odd_timeout_%0d: got %0d frames expected 1", i, rx_q.size());
      end else begin
        e = sb_q.pop_front();
        o = rx_q.pop_front();
        checks++;
        if (o.data !== e.data) begin
          errors++;
          $display("[TB] FAIL odd_data_%0d: got %h expected %h", i, o.data, e.data);
        end
        checks++;
        if (o.par !== e.par) begin
          errors++;
          $display("[TB] FAIL odd_par_%0d: got %b expected %b", i, o.par, e.par);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int   n;
    bit   ok;
    exp_t e;
    obs_t o;
    logic [7:0] b;
    n = DEPTH + 2;
    parity = 1'b0;
    for (int i = 0; i < n; i++) begin
      b = 8'((i + 1) * 17);
      din   = b;
      wr_en = 1'b1;
      if (i < n - 1) sb_q.push_back('{data: b, par: model_par(b, 1'b0)});
      if (i == n - 1) begin
        checks++;
        if (full !== 1'b1) begin
          errors++;
          $display("[TB] FAIL full_before_drop: got %b expected 1", full);
        end
      end
      @(negedge clk);
      checks++;
      if (ovf !== logic'(i == n - 1)) begin
        errors++;
        $display("[TB] FAIL ovf_write_%0d: got %b expected %b", i, ovf, logic'(i == n - 1));
      end
    end
    wr_en = 1'b0;
    @(negedge clk);
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_clear: got %b expected 0", ovf);
    end
    wait_frames(n - 1, 12 * n + 20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL b2b_timeout: got %0d frames expected %0d", rx_q.size(), n - 1);
    end
    for (int i = 0; i < n - 1; i++) begin
      if (rx_q.size() == 0 || sb_q.size() == 0) break;
      e = sb_q.pop_front();
      o = rx_q.pop_front();
      checks++;
      if (o.data !== e.data) begin
        errors++;
        $display("[TB] FAIL b2b_data_%0d: got %h expected %h", i, o.data, e.data);
      end
      checks++;
      if (o.par !== e.par) begin
        errors++;
        $display("[TB] FAIL b2b_par_%0d: got %b expected %b", i, o.par, e.par);
      end
      if (i > 0) begin
        checks++;
        if (o.gap !== 0) begin
          errors++;
          $display("[TB] FAIL b2b_gap_%0d: got %0d expected 0", i, o.gap);
        end
      end
    end
    sb_q.delete();
    rx_q.delete();
  endtask

  task automatic test_baud_divider;
    logic [10:0] fb;
    int tx_err, strt_cnt, fd_cnt, fd_at;
    fb = {1'b1, model_par(8'hFF, 1'b0), 8'hFF, 1'b0};
    tx_err = 0; strt_cnt = 0; fd_cnt = 0; fd_at = -1;
    parity4 = 1'b0;
    din4    = 8'hFF;
    wr_en4  = 1'b1;
    @(negedge clk);
    wr_en4  = 1'b0;
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL baud_busy_start: got %b expected 1", busy4);
    end
    for (int c = 0; c < 44; c++) begin
      if (tx4 !== fb[c / 4]) tx_err++;
      if (strt4 === 1'b1) strt_cnt++;
      if (fd4 === 1'b1) begin
        fd_cnt++;
        fd_at = c;
      end
      @(negedge clk);
    end
    checks++;
    if (tx_err !== 0) begin
      errors++;
      $display("[TB] FAIL baud_tx_pattern: got %0d wrong cycles expected 0", tx_err);
    end
    checks++;
    if (strt_cnt !== 36) begin
      errors++;
      $display("[TB] FAIL baud_strt_beg_len: got %0d expected 36", strt_cnt);
    end
    checks++;
    if (fd_cnt !== 1 || fd_at !== 43) begin
      errors++;
      $display("[TB] FAIL baud_frame_done: got %0d pulses at %0d expected 1 at 43", fd_cnt, fd_at);
    end
    checks++;
    if ({busy4, tx4} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL baud_idle_after: got %b expected 01", {busy4, tx4});
    end
  endtask

  task automatic test_reset_midframe;
    int idle_err, rx_before;
    din    = 8'h00;
    parity = 1'b0;
    wr_en  = 1'b1;
    @(negedge clk);
    wr_en  = 1'b0;
    @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    if ({tx, strt_beg} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL midframe_pre: got %b expected 01", {tx, strt_beg});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx, busy, strt_beg, empty} !== 4'b1001) begin
      errors++;
      $display("[TB] FAIL midframe_reset: got %b expected 1001", {tx, busy, strt_beg, empty});
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    rx_before = rx_q.size();
    idle_err  = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) idle_err++;
    end
    checks++;
    if (idle_err !== 0 || rx_q.size() !== rx_before) begin
      errors++;
      $display("[TB] FAIL midframe_idle: got %0d busy cycles %0d frames expected 0 0",
               idle_err, rx_q.size() - rx_before);
    end
  endtask

  task automatic test_loopback;
    bit   ok;
    exp_t e;
    obs_t o;
    logic perr;
    logic [7:0] bytes [3];
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    bytes[2] = 8'h5A;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 3; i++) begin
        send_byte(bytes[i], logic'(p));
        wait_frames(1, 30, ok);
        checks++;
        if (!ok) begin
          errors++;
          $display("[TB] FAIL loop_timeout_p%0d_%0d: got %0d frames expected 1", p, i, rx_q.size());
        end else begin
          e = sb_q.pop_front();
          o = rx_q.pop_front();
          perr = logic'((($countones(o.data) + int'(o.par)) % 2) != p);
          checks++;
          if (o.data !== e.data) begin
            errors++;
            $display("[TB] FAIL loop_data_p%0d_%0d: got %h expected %h", p, i, o.data, e.data);
          end
          checks++;
          if (perr !== 1'b0 || o.strt_ok !== 1'b1) begin
            errors++;
            $display("[TB] FAIL loop_parity_error_p%0d_%0d: got %b expected 0", p, i, perr);
          end
        end
      end
    end
  endtask

  // Global time limit so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_even_parity();
    test_odd_parity();
    test_back_to_back();
    test_baud_divider();
    test_reset_midframe();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_piso_fifo.md
# uart_tx_piso_fifo

Transmit-side counterpart of the serial receiver shift register: it accepts parallel bytes from the host, buffers them, and serialises each one as a framed bit stream (start bit, 8 data bits LSB first, parity bit, stop bit) on a single line. The parity bit matches what the receiver checks for the same `parity` setting. The block sits between the host write port and the serial link, one byte per frame, with back-to-back frames when bytes are queued.

## Interface
Parameters:
- `CLKS_PER_BIT`, 1: clock cycles each serial bit is held. Legal range 1..255. The receiver consumes one bit per `clk`, so 1 is the matched setting.
- `FIFO_DEPTH`, 4: byte buffer depth, power of 2, range 2..16. Used only when `TX_FIFO_EN` is defined.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `wr_en` input 1: write strobe; `din` is captured on the same edge.
- `din` input 8: byte to send.
- `parity` input 1: 0 = even, 1 = odd. Sampled when a byte is popped into the shifter.
- `tx` output 1: serial line, idle high.
- `strt_beg` output 1: high for every cycle from the first data bit through the parity bit. Drives the receiver's frame-enable.
- `busy` output 1: high while the FSM is not in IDLE.
- `full` output 1: buffer full.
- `empty` output 1: buffer empty.
- `ovf` output 1: one-cycle pulse when a write is dropped.
- `frame_done` output 1: one-cycle pulse on the last cycle of STOP.

## Operation
- Buffer: circular FIFO with read/write pointers that have an extra wrap bit. `full` and `empty` are derived combinationally from the pointers.
- FSM states: IDLE, START, DATA, PAR, STOP. A bit counter (0..7) and a baud counter (0..`CLKS_PER_BIT`-1) run alongside the FSM.
- IDLE: `tx`=1. If the buffer is not empty:
  - pop the head byte into the 8-bit shifter;
  - latch `parity`;
  - compute the parity bit: even = XOR of the 8 bits, odd = XNOR of the 8 bits;
  - go to START.
- START: `tx`=0 for one bit time, then go to DATA.
- DATA: `tx`=shifter[0]. At the end of each bit time, shift right and increment the bit counter. After bit 7, go to PAR.
- PAR: `tx`=the latched parity bit for one bit time, then go to STOP.
- STOP: `tx`=1 for one bit time. At the end of STOP:
  - pulse `frame_done`;
  - if the buffer is not empty, pop and go directly to START (no idle bit);
  - otherwise go to IDLE.
- Write while full, with no pop on the same edge: the byte is dropped and `ovf` pulses. Write while full with a pop on the same edge: the write is accepted and the buffer stays full.
- `tx` and `strt_beg` are registered outputs (no combinational glitches).

## Timing
- Reset (asynchronous, immediate; also applies when asserted mid-frame):
  - `tx`=1, `strt_beg`=0, `busy`=0, `full`=0, `empty`=1, `ovf`=0, `frame_done`=0;
  - FSM goes to IDLE, all pointers and counters clear, buffered bytes are discarded, and any partial frame is abandoned.
- Latency: a write at edge N into an empty buffer while IDLE makes `empty`=0 after N. The pop and the transition to START happen at edge N+1, so `tx` falls after edge N+1.
- Frame length: 11×`CLKS_PER_BIT` cycles. Bit k of a frame occupies cycles [k×CPB, (k+1)×CPB) after START entry, where CPB is `CLKS_PER_BIT`.
- `busy` rises on entry to START and falls on the edge that enters IDLE.
- `strt_beg` is high exactly for 9×CPB cycles: the DATA bits plus the PAR bit.
- `parity` and `din` changes during a frame do not affect the frame in flight.

## Configuration
- `TX_FIFO_EN` defined: the buffer is `FIFO_DEPTH` bytes deep.
- `TX_FIFO_EN` undefined: the buffer is a single holding register.
  - `full` = holding register valid; `empty` = its inverse.
  - The register frees on the pop at START entry, so one byte can be queued while another shifts.
  - All other behaviour is identical.

## Test plan
- Even parity, matched rate: reset, `parity`=0, write 0xA5 with CPB=1 → `tx` sequence 0, 1,0,1,0,0,1,0,1, 0, 1. The parity bit is 0 because 0xA5 has four ones. `frame_done` pulses once.
- Odd parity: write 0x07 with `parity`=1 → data bits 1,1,1,0,0,0,0,0, parity bit 0. Write 0x03 → parity bit 1.
- Back-to-back and overflow, `TX_FIFO_EN`, depth 4:
  - write 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles;
  - 0x11 pops first, so 0x22–0x55 fill the buffer;
  - a sixth write (0x66) while `full` → `ovf` pulse, byte dropped;
  - five frames are sent back-to-back with no idle bits.
- Baud divider: CPB=4, write 0xFF, `parity`=0 → each bit held 4 cycles, frame lasts 44 cycles, parity bit 0, `strt_beg` high for 36 cycles.
- Reset mid-frame: assert `rst`=0 during DATA bit 3 → `tx`=1 and `busy`=0 immediately. After release, the line stays idle until a new write.
- Loopback: connect `tx`/`strt_beg` to the receiver (data bits and parity) and send 0x00, 0xFF, 0x5A under both parities → received `data` matches and `parity_error` stays 0.
